// File: rtl/mem_word_writer.sv
// mem_word_writer: writes 32-bit words big-endian as four byte strobes; MEM_WRITER_ALIGN_CHECK_EN also rejects misaligned addresses.
module mem_word_writer #(
  parameter int ADDR_W   = 10,
  parameter int MAX_ADDR = 526
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_auto,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] next_addr,
  output logic [15:0]       word_count
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_n;
  logic [1:0] idx;
  logic [ADDR_W-1:0] lat_addr, eff;
  logic [31:0] lat_data;
  logic acc, bad, misalign;
  always_comb begin
    in_ready = state == IDLE && !rst;
    acc = in_valid && in_ready;
    eff = in_auto ? next_addr : in_addr[ADDR_W-1:0];
`ifdef MEM_WRITER_ALIGN_CHECK_EN
    misalign = eff[1:0] != 2'd0;
`else
    misalign = 1'b0;
`endif
    // last byte must fit, and explicit addresses may not carry bits beyond the memory
    bad = (33'(eff) + 33'd3 > 33'(MAX_ADDR)) || (!in_auto && (in_addr >> ADDR_W) != 32'd0) || misalign;
    busy = state == WRITE;
    done = busy && idx == 2'd3;
    mem_we = busy;
    mem_addr = busy ? lat_addr + ADDR_W'(idx) : '0;
    mem_wdata = !busy ? 8'd0 : idx == 2'd0 ? lat_data[31:24] : idx == 2'd1 ? lat_data[23:16] :
                idx == 2'd2 ? lat_data[15:8] : lat_data[7:0];
    state_n = state == IDLE ? (acc && !bad ? WRITE : IDLE) : (done ? IDLE : WRITE);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 2'd0;
      lat_addr <= '0;
      lat_data <= 32'd0;
      next_addr <= '0;
      word_count <= 16'd0;
      err <= 1'b0;
    end else begin
      err <= acc && bad;
      if (acc && !bad) begin
        lat_addr <= eff;
        lat_data <= in_data;
        idx <= 2'd0;
      end else if (busy) idx <= idx + 2'd1;
      if (done) begin
        word_count <= word_count + 16'd1;
        next_addr <= lat_addr + ADDR_W'(4);
      end
    end
  end
endmodule

// File: tb/tb_mem_word_writer.sv
// tb_mem_word_writer: directed vectors for mem_word_writer with a small address/count model.
module tb_mem_word_writer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_auto = 1'b0;
  logic [31:0] in_addr = 32'd0, in_data = 32'd0;
  logic in_ready, mem_we, busy, done, err;
  logic [9:0] mem_addr, next_addr;
  logic [7:0] mem_wdata;
  logic [15:0] word_count;
  int n_chk = 0, n_pass = 0;
  logic [9:0] m_next;
  logic [15:0] m_count;
  always #5 clk = ~clk;
  mem_word_writer #(.ADDR_W(10), .MAX_ADDR(526)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_auto(in_auto),
    .in_addr(in_addr), .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .next_addr(next_addr),
    .word_count(word_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    m_next = 10'd0;
    m_count = 16'd0;
    chk("rst_ready_rel", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_next", next_addr, 0);
    chk("rst_count", word_count, 0);
  endtask
  task automatic do_word(input logic auto, input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
    logic [9:0] a;
    a = auto ? m_next : addr[9:0];
    in_valid = 1'b1;
    in_auto = auto;
    in_addr = addr;
    in_data = data;
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_err) begin
      chk("err_pulse", err, 1);
      chk("err_we", mem_we, 0);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_we2", mem_we, 0);
      chk("err_next", next_addr, m_next);
      chk("err_count", word_count, m_count);
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("byte_we", mem_we, 1);
        chk("byte_busy", busy, 1);
        chk("byte_ready", in_ready, 0);
        chk("byte_addr", mem_addr, a + 10'(k));
        chk("byte_data", mem_wdata, (data >> (24 - 8 * k)) & 32'hff);
        chk("byte_done", done, k == 3);
        chk("byte_err", err, 0);
        @(negedge clk);
      end
      m_next = a + 10'd4;
      m_count = m_count + 16'd1;
      chk("post_ready", in_ready, 1);
      chk("post_we", mem_we, 0);
      chk("post_done", done, 0);
      chk("post_next", next_addr, m_next);
      chk("post_count", word_count, m_count);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int acc_cyc[3];
    logic [9:0] wr_addr[3];
    int n_acc, n_wr;
    logic prev_we;
    do_reset();
    do_word(1'b0, 32'h10, 32'h12345678, 1'b0);
    do_reset();
    in_valid = 1'b1;
    in_auto = 1'b1;
    in_data = 32'hDEADBEEF;
    n_acc = 0;
    n_wr = 0;
    prev_we = 1'b0;
    acc_cyc = '{0, 0, 0};
    wr_addr = '{10'd0, 10'd0, 10'd0};
    for (int c = 0; c < 40; c++) begin
      if (in_valid && in_ready && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (mem_we && !prev_we && n_wr < 3) begin
        wr_addr[n_wr] = mem_addr;
        n_wr++;
      end
      prev_we = mem_we;
      @(negedge clk);
      if (n_acc == 3) in_valid = 1'b0;
    end
    chk("b2b_nacc", n_acc, 3);
    chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 5);
    chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 5);
    chk("b2b_nwr", n_wr, 3);
    chk("b2b_addr0", wr_addr[0], 0);
    chk("b2b_addr1", wr_addr[1], 4);
    chk("b2b_addr2", wr_addr[2], 8);
    chk("b2b_next", next_addr, 12);
    chk("b2b_count", word_count, 3);
    do_reset();
    do_word(1'b0, 32'd524, 32'h11223344, 1'b1);
    do_word(1'b0, 32'd523, 32'hA1B2C3D4, 1'b0);
    do_word(1'b1, 32'd0, 32'h55667788, 1'b1);
    do_word(1'b0, 32'h410, 32'h99AABBCC, 1'b1);
`ifdef MEM_WRITER_ALIGN_CHECK_EN
    do_word(1'b0, 32'h21, 32'hCAFEBABE, 1'b1);
`else
    do_word(1'b0, 32'h21, 32'hCAFEBABE, 1'b0);
    chk("mis_next", next_addr, 10'h25);
`endif
    do_reset();
    in_valid = 1'b1;
    in_auto = 1'b0;
    in_addr = 32'h40;
    in_data = 32'h0BADF00D;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_b1_addr", mem_addr, 10'h41);
    chk("abort_b1_data", mem_wdata, 8'hAD);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_we", mem_we, 0);
      chk("abort_done", done, 0);
      chk("abort_ready", in_ready, 1);
      chk("abort_count", word_count, 0);
      chk("abort_next", next_addr, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_word_writer.md
MEM_WORD_WRITER -- requirements
Module: mem_word_writer

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of the target memory.
REQ-002 Parameter MAX_ADDR, default 526, highest writable byte address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  word write request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_auto  input  1  1 = use internal pointer as address, 0 = use in_addr.
REQ-008 in_addr  input  32  byte address of the word's first (most significant) byte.
REQ-009 in_data  input  32  word to store, big-endian.
REQ-010 mem_we  output  1  byte write strobe to memory.
REQ-011 mem_addr  output  ADDR_W  byte address for the current write.
REQ-012 mem_wdata  output  8  byte to write.
REQ-013 busy  output  1  high while a word is being written.
REQ-014 done  output  1  one-cycle pulse marking the last byte of a word.
REQ-015 err  output  1  one-cycle pulse marking a rejected request.
REQ-016 next_addr  output  ADDR_W  current auto-increment pointer.
REQ-017 word_count  output  16  number of words completed since reset.

Function
REQ-018 FSM states: IDLE and WRITE; a 2-bit byte index selects the byte within WRITE.
REQ-019 in_ready shall be 1 exactly when the FSM is in IDLE and rst is low.
REQ-020 A request is accepted in a cycle where in_valid and in_ready are both 1; in that cycle the effective address is next_addr if in_auto=1, else in_addr[ADDR_W-1:0].
REQ-021 Range check: if the effective address plus 3 exceeds MAX_ADDR, or in_auto=0 and any in_addr bit at or above ADDR_W is set, the request is rejected.
REQ-022 Rejected request: err=1 in the next cycle, FSM stays in IDLE, no mem_we, next_addr and word_count unchanged.
REQ-023 Accepted request: address and data are latched and the FSM enters WRITE in the next cycle.
REQ-024 In WRITE, for 4 consecutive cycles k=0..3: mem_we=1, mem_addr=latched address+k, mem_wdata=in_data[31-8k:24-8k].
REQ-025 done=1 in the same cycle as byte k=3; in that cycle word_count increments (wrapping at 2^16) and next_addr becomes latched address+4, modulo 2^ADDR_W.
REQ-026 The FSM returns to IDLE the cycle after byte 3; latency is acceptance at T, bytes at T+1..T+4, in_ready=1 again at T+5.
REQ-027 busy=1 exactly while the FSM is in WRITE; in_valid and inputs are ignored while busy.
REQ-028 Outside WRITE: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 next_addr updates only on completed words; in_auto=0 writes also advance it, to their address+4.

Reset
REQ-030 rst shall take priority over all other activity.
REQ-031 When rst=1 at a clock edge, the block enters IDLE and sets next_addr=0, word_count=0, and busy, done, err, mem_we, mem_addr, mem_wdata all to 0.
REQ-032 Reset during WRITE aborts the word: remaining bytes are not written, no done pulse, word_count unchanged (cleared).

Configuration
REQ-033 Macro MEM_WRITER_ALIGN_CHECK_EN defined: an effective address with bits [1:0] not equal to 0 is additionally rejected per REQ-022.
REQ-034 Macro MEM_WRITER_ALIGN_CHECK_EN undefined: misaligned addresses are accepted and written byte-wise per REQ-024, subject only to the range check.

Verification
REQ-035 Reset, then in_auto=0, in_addr=0x10, in_data=0x12345678 -> bytes 0x12,0x34,0x56,0x78 written to addresses 0x10-0x13 in consecutive cycles; done with the 0x78 write; next_addr=0x14; word_count=1.
REQ-036 Reset, then three in_auto=1 requests held valid back-to-back -> writes at 0,4,8; requests accepted 5 cycles apart; next_addr=12; word_count=3.
REQ-037 in_addr=524 (MAX_ADDR=526) -> err pulse, no mem_we; in_addr=523 -> accepted and bytes written to 523-526.
REQ-038 in_addr=0x21 -> with MEM_WRITER_ALIGN_CHECK_EN, err pulse and no writes; without it, writes to 0x21-0x24 and next_addr=0x25.
REQ-039 rst asserted on the cycle of byte 1 -> next cycle mem_we=0, in_ready=1, word_count=0, next_addr=0, no done pulse.
